exp_frame_ctrl_16: RTL and testbench

Frame-level sequencer in front of the 16-bit exp output stage of the softmax pipeline. It accepts one AXI4-Stream frame of 1.7.8 signed logits and buffers it while tracking the running maximum. It then issues (x - max) one sample per cycle to the exp stage, pulses the done strobe that latches the sample count, and holds off the next frame until the exp stage's output stream has emitted its last beat. It also re-arms the exp stage between frames through a one-cycle active-low clear.

---
 rtl/softmax_pkg_16.sv | 38 +++
 rtl/sat_sub_16.sv | 32 +++
 rtl/exp_frame_ctrl_16.sv | 182 ++++++++++++++++++
 tb/tb_exp_frame_ctrl_16.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg_16.sv
// softmax_pkg_16
// Shared definitions for the 16-bit softmax pipeline stages.
//   - 1.7.8 signed fixed-point format widths
//   - sample extremes used for max tracking and exp-safe saturation
//   - frame controller state encoding
// No ports (package).
package softmax_pkg_16;

    // 1.7.8 format: sign + 7 integer bits, 8 fractional bits
    localparam int FMT_INT_BITS  = 8;
    localparam int FMT_FRAC_BITS = 8;
    localparam int FMT_WIDTH     = FMT_INT_BITS + FMT_FRAC_BITS;

    // Most negative sample; seeds the running maximum
    localparam logic [FMT_WIDTH-1:0] SAMPLE_MIN   = 16'h8000;
    // Most positive sample
    localparam logic [FMT_WIDTH-1:0] SAMPLE_MAX   = 16'h7FFF;
    // Lowest value the exp stage may see: its negation of 0x8000 overflows
    localparam logic [FMT_WIDTH-1:0] EXP_SAFE_MIN = 16'h8001;

    // Frame controller state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        CLEAR = ST_CLEAR,
        LOAD  = ST_LOAD,
        ISSUE = ST_ISSUE,
        DONE  = ST_DONE,
        DRAIN = ST_DRAIN
    } ctrlState_t;

endpackage

// File: rtl/sat_sub_16.sv
// sat_sub_16
// Combinational signed subtract a - b in 1.7.8 with saturation.
// Results below -0x7FFF clamp to 0x8001 (never 0x8000), results above
// 0x7FFF clamp to 0x7FFF.
// Ports:
//   a_i    in  16  minuend, signed
//   b_i    in  16  subtrahend, signed
//   diff_o out 16  saturated difference
module sat_sub_16
    import softmax_pkg_16::*;
(
    input  logic [FMT_WIDTH-1:0] a_i,
    input  logic [FMT_WIDTH-1:0] b_i,
    output logic [FMT_WIDTH-1:0] diff_o
);

    logic signed [FMT_WIDTH:0] wideDiff;

    // One extra bit holds any difference of two 16-bit signed values exactly
    assign wideDiff = $signed({a_i[FMT_WIDTH-1], a_i}) - $signed({b_i[FMT_WIDTH-1], b_i});

    // Clamp against the sign-extended safe minimum and the positive maximum
    always_comb begin
        diff_o = wideDiff[FMT_WIDTH-1:0];
        if (wideDiff < $signed({1'b1, EXP_SAFE_MIN})) begin
            diff_o = EXP_SAFE_MIN;
        end else if (wideDiff > $signed({1'b0, SAMPLE_MAX})) begin
            diff_o = SAMPLE_MAX;
        end
    end

endmodule

// File: rtl/exp_frame_ctrl_16.sv
// exp_frame_ctrl_16
// Frame sequencer in front of the 16-bit exp stage. Buffers one AXI4-Stream
// frame of 1.7.8 logits while tracking the maximum, issues (x - max) one per
// cycle, pulses a done strobe, then waits for the exp stage's last output
// beat before accepting the next frame. The exp stage is cleared through a
// one-cycle active-low pulse before each frame.
// Optional feature macro: EXP_CTRL_STATS_EN adds frame_cnt_o / ovf_cnt_o.
// Ports:
//   clock_i, reset_i            clock, synchronous active-high reset
//   s_axis_data/valid/last_i    input frame stream
//   s_axis_ready_o              high only while loading
//   exp_data_o, exp_data_valid_o issued differences to the exp stage
//   exp_sub_2_done_o            pulse one cycle after the last issue
//   exp_rst_n_o                 active-low clear to the exp stage
//   drain_valid/ready/last_i    monitored exp stage output handshake
//   busy_o                      high whenever not idle
//   overflow_o                  frame had more than max_n beats
//   frame_cnt_o, ovf_cnt_o      (EXP_CTRL_STATS_EN only) frame statistics
module exp_frame_ctrl_16
    import softmax_pkg_16::*;
#(
    parameter int data_size = FMT_WIDTH,
    parameter int max_n     = 10,
    parameter int cnt_w     = 8
)
(
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [data_size-1:0] s_axis_data_i,
    input  logic                 s_axis_valid_i,
    input  logic                 s_axis_last_i,
    output logic                 s_axis_ready_o,
    output logic [data_size-1:0] exp_data_o,
    output logic                 exp_data_valid_o,
    output logic                 exp_sub_2_done_o,
    output logic                 exp_rst_n_o,
    input  logic                 drain_valid_i,
    input  logic                 drain_ready_i,
    input  logic                 drain_last_i,
    output logic                 busy_o,
    output logic                 overflow_o
`ifdef EXP_CTRL_STATS_EN
    ,
    output logic [15:0]          frame_cnt_o,
    output logic [7:0]           ovf_cnt_o
`endif
);

    localparam int IDX_W = (max_n > 1) ? $clog2(max_n) : 1;

    ctrlState_t           state_q, state_d;
    logic [cnt_w-1:0]     wrCnt_q, rdCnt_q;
    logic [data_size-1:0] max_q;
    logic [data_size-1:0] sampleBuf_q [max_n];
    logic [data_size-1:0] expData_q;
    logic                 expValid_q, done_q, expRstN_q, ready_q, busy_q, overflow_q;

    logic                 accept, bufFull, lastRead, drainDone;
    logic [IDX_W-1:0]     wrIdx, rdIdx;
    logic [data_size-1:0] rdSample, issueDiff;

    assign accept    = ready_q & s_axis_valid_i;
    assign bufFull   = (wrCnt_q == cnt_w'(max_n));
    assign lastRead  = (rdCnt_q == wrCnt_q - cnt_w'(1));
    assign drainDone = drain_valid_i & drain_ready_i & drain_last_i;
    assign wrIdx     = wrCnt_q[IDX_W-1:0];
    assign rdIdx     = rdCnt_q[IDX_W-1:0];
    assign rdSample  = sampleBuf_q[rdIdx];

    sat_sub_16 u_satSub (
        .a_i    (rdSample),
        .b_i    (max_q),
        .diff_o (issueDiff)
    );

    // Next-state decode; the registered outputs below are derived from it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_axis_valid_i) state_d = CLEAR;
            CLEAR:   state_d = LOAD;
            LOAD:    if (accept && s_axis_last_i) state_d = ISSUE;
            ISSUE:   if (lastRead) state_d = DONE;
            DONE:    state_d = DRAIN;
            DRAIN:   if (drainDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sample storage; contents are only meaningful below wrCnt_q so no reset
    always_ff @(posedge clock_i) begin
        if (accept && !bufFull) begin
            sampleBuf_q[wrIdx] <= s_axis_data_i;
        end
    end

    // Control FSM with registered outputs. Level outputs follow the next
    // state so they line up with the state register; issue data, valid and
    // the done strobe are produced one cycle after the state that owns them.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            wrCnt_q    <= '0;
            rdCnt_q    <= '0;
            max_q      <= SAMPLE_MIN;
            expData_q  <= '0;
            expValid_q <= 1'b0;
            done_q     <= 1'b0;
            expRstN_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= (state_d == LOAD);
            busy_q     <= (state_d != IDLE);
            expRstN_q  <= (state_d != CLEAR);
            expValid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                CLEAR: begin
                    wrCnt_q    <= '0;
                    rdCnt_q    <= '0;
                    overflow_q <= 1'b0;
                    max_q      <= SAMPLE_MIN;
                end
                LOAD: begin
                    if (accept) begin
                        if (!bufFull) begin
                            wrCnt_q <= wrCnt_q + cnt_w'(1);
                            if ($signed(s_axis_data_i) > $signed(max_q)) begin
                                max_q <= s_axis_data_i;
                            end
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    expData_q  <= issueDiff;
                    expValid_q <= 1'b1;
                    rdCnt_q    <= rdCnt_q + cnt_w'(1);
                end
                DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef EXP_CTRL_STATS_EN
    logic [15:0] frameCnt_q;
    logic [7:0]  ovfCnt_q;

    // Frames are counted when the exp stage has fully drained them
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            frameCnt_q <= '0;
            ovfCnt_q   <= '0;
        end else if (state_q == DRAIN && drainDone) begin
            frameCnt_q <= frameCnt_q + 16'd1;
            if (overflow_q && ovfCnt_q != 8'hFF) begin
                ovfCnt_q <= ovfCnt_q + 8'd1;
            end
        end
    end

    assign frame_cnt_o = frameCnt_q;
    assign ovf_cnt_o   = ovfCnt_q;
`endif

    assign s_axis_ready_o   = ready_q;
    assign exp_data_o       = expData_q;
    assign exp_data_valid_o = expValid_q;
    assign exp_sub_2_done_o = done_q;
    assign exp_rst_n_o      = expRstN_q;
    assign busy_o           = busy_q;
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_exp_frame_ctrl_16.sv
// tb_exp_frame_ctrl_16
// Self-checking bench for exp_frame_ctrl_16. Expected issue values are
// computed from a small model of max tracking and saturated subtraction,
// pushed to a queue as each frame is driven, and popped as the DUT issues.
module tb_exp_frame_ctrl_16;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [15:0] s_axis_data_i;
    logic        s_axis_valid_i, s_axis_last_i, s_axis_ready_o;
    logic [15:0] exp_data_o;
    logic        exp_data_valid_o, exp_sub_2_done_o, exp_rst_n_o;
    logic        drain_valid_i, drain_ready_i, drain_last_i;
    logic        busy_o, overflow_o;
`ifdef EXP_CTRL_STATS_EN
    logic [15:0] frame_cnt_o;
    logic [7:0]  ovf_cnt_o;
`endif

    int          checks = 0;
    int          errors = 0;
    int          issuedCnt = 0;
    logic        prevValid = 1'b0;
    logic [15:0] monExp;
    logic [15:0] expQ [$];
    logic [15:0] stim [16];

    always #5 clock_i = ~clock_i;

    exp_frame_ctrl_16 dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .s_axis_data_i    (s_axis_data_i),
        .s_axis_valid_i   (s_axis_valid_i),
        .s_axis_last_i    (s_axis_last_i),
        .s_axis_ready_o   (s_axis_ready_o),
        .exp_data_o       (exp_data_o),
        .exp_data_valid_o (exp_data_valid_o),
        .exp_sub_2_done_o (exp_sub_2_done_o),
        .exp_rst_n_o      (exp_rst_n_o),
        .drain_valid_i    (drain_valid_i),
        .drain_ready_i    (drain_ready_i),
        .drain_last_i     (drain_last_i),
        .busy_o           (busy_o),
        .overflow_o       (overflow_o)
`ifdef EXP_CTRL_STATS_EN
        ,
        .frame_cnt_o      (frame_cnt_o),
        .ovf_cnt_o        (ovf_cnt_o)
`endif
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard consumer: every issued sample must match the queue head,
    // and the done strobe must directly follow an issued sample
    always @(negedge clock_i) begin
        if (exp_data_valid_o) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_issue", 32'(exp_data_valid_o), 32'd0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("exp_data", 32'(exp_data_o), 32'(monExp));
            end
            issuedCnt++;
        end
        if (exp_sub_2_done_o) begin
            checkOutput("done_after_last", 32'(prevValid), 32'd1);
        end
        prevValid = exp_data_valid_o;
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(s_axis_ready_o), 32'd0);
        checkOutput({tag, "_data"},  32'(exp_data_o), 32'd0);
        checkOutput({tag, "_valid"}, 32'(exp_data_valid_o), 32'd0);
        checkOutput({tag, "_done"},  32'(exp_sub_2_done_o), 32'd0);
        checkOutput({tag, "_rstn"},  32'(exp_rst_n_o), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy_o), 32'd0);
        checkOutput({tag, "_ovf"},   32'(overflow_o), 32'd0);
    endtask

    // Model the frame into the scoreboard, then drive it from IDLE
    task automatic applyStimulus(input int n);
        int mx;
        int d;
        int kept;
        int guard;
        kept = (n > 10) ? 10 : n;
        mx = -32768;
        for (int i = 0; i < kept; i++) begin
            if (int'($signed(stim[i])) > mx) mx = int'($signed(stim[i]));
        end
        for (int i = 0; i < kept; i++) begin
            d = int'($signed(stim[i])) - mx;
            if (d < -32767) expQ.push_back(16'h8001);
            else expQ.push_back(16'(d));
        end
        s_axis_data_i  = stim[0];
        s_axis_valid_i = 1'b1;
        s_axis_last_i  = (n == 1);
        @(negedge clock_i);
        checkOutput("clear_rstn_low", 32'(exp_rst_n_o), 32'd0);
        checkOutput("clear_ready_low", 32'(s_axis_ready_o), 32'd0);
        for (int i = 0; i < n; i++) begin
            s_axis_data_i  = stim[i];
            s_axis_last_i  = (i == n - 1);
            s_axis_valid_i = 1'b1;
            guard = 0;
            while (!s_axis_ready_o && guard < 20) begin
                @(negedge clock_i);
                guard++;
            end
            if (guard >= 20) checkOutput("ready_timeout", 32'(s_axis_ready_o), 32'd1);
            @(posedge clock_i);
            #1;
        end
        s_axis_valid_i = 1'b0;
        s_axis_last_i  = 1'b0;
        @(negedge clock_i);
        checkOutput("latency_not_early", 32'(exp_data_valid_o), 32'd0);
        @(negedge clock_i);
        checkOutput("latency_first_issue", 32'(exp_data_valid_o), 32'd1);
    endtask

    task automatic waitDone(input logic expOvf);
        int guard;
        guard = 0;
        while (!exp_sub_2_done_o && guard < 100) begin
            @(negedge clock_i);
            guard++;
        end
        checkOutput("done_seen", 32'(exp_sub_2_done_o), 32'd1);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("overflow", 32'(overflow_o), 32'(expOvf));
        checkOutput("ready_low_after_done", 32'(s_axis_ready_o), 32'd0);
    endtask

    // Partial handshakes must hold DRAIN; only the full triple releases it
    task automatic drainFrame();
        @(posedge clock_i); #1;
        drain_valid_i = 1'b1; drain_ready_i = 1'b1; drain_last_i = 1'b0;
        @(negedge clock_i);
        checkOutput("drain_busy", 32'(busy_o), 32'd1);
        checkOutput("drain_ready_low", 32'(s_axis_ready_o), 32'd0);
        @(posedge clock_i); #1;
        drain_valid_i = 1'b1; drain_ready_i = 1'b0; drain_last_i = 1'b1;
        @(negedge clock_i);
        checkOutput("drain_hold_no_last", 32'(busy_o), 32'd1);
        @(posedge clock_i); #1;
        checkOutput("drain_hold_no_ready", 32'(busy_o), 32'd1);
        drain_ready_i = 1'b1;
        @(posedge clock_i); #1;
        drain_valid_i = 1'b0; drain_ready_i = 1'b0; drain_last_i = 1'b0;
        @(negedge clock_i);
        checkOutput("idle_not_busy", 32'(busy_o), 32'd0);
        checkOutput("idle_rstn_high", 32'(exp_rst_n_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int base;
        int guard;
        reset_i = 1'b1;
        s_axis_data_i = '0; s_axis_valid_i = 1'b0; s_axis_last_i = 1'b0;
        drain_valid_i = 1'b0; drain_ready_i = 1'b0; drain_last_i = 1'b0;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        checkResetValues("reset");
        @(posedge clock_i); #1;
        reset_i = 1'b0;

        $display("[TB] frame 1: three beats");
        stim[0] = 16'h0100; stim[1] = 16'h0300; stim[2] = 16'h0200;
        applyStimulus(3);
        waitDone(1'b0);
        drainFrame();

        $display("[TB] frame 2: saturation to 0x8001");
        stim[0] = 16'h7F00; stim[1] = 16'h8000;
        applyStimulus(2);
        waitDone(1'b0);
        drainFrame();

        $display("[TB] frame 3: twelve beats, overflow");
        for (int i = 0; i < 12; i++) stim[i] = 16'(i * 16'h0123) ^ 16'hFA5A;
        stim[11] = 16'h7FFF;
        applyStimulus(12);
        waitDone(1'b1);
        drainFrame();

        $display("[TB] frame 4: four beats after overflow");
        for (int i = 0; i < 4; i++) stim[i] = 16'($urandom_range(0, 65535));
        applyStimulus(4);
        checkOutput("overflow_cleared", 32'(overflow_o), 32'd0);
        waitDone(1'b0);
        drainFrame();

        $display("[TB] frame 5: single beat");
        stim[0] = 16'hF000;
        applyStimulus(1);
        waitDone(1'b0);
        drainFrame();

`ifdef EXP_CTRL_STATS_EN
        checkOutput("frame_cnt", 32'(frame_cnt_o), 32'd5);
        checkOutput("ovf_cnt", 32'(ovf_cnt_o), 32'd1);
`endif

        $display("[TB] frame 6: reset during issue");
        for (int i = 0; i < 5; i++) stim[i] = 16'(16'h0040 * i);
        base = issuedCnt;
        applyStimulus(5);
        guard = 0;
        while ((issuedCnt - base) < 2 && guard < 20) begin
            @(negedge clock_i); #1;
            guard++;
        end
        checkOutput("two_issued_before_reset", 32'(issuedCnt - base), 32'd2);
        reset_i = 1'b1;
        expQ.delete();
        @(negedge clock_i);
        checkResetValues("mid_reset");
`ifdef EXP_CTRL_STATS_EN
        checkOutput("frame_cnt_reset", 32'(frame_cnt_o), 32'd0);
        checkOutput("ovf_cnt_reset", 32'(ovf_cnt_o), 32'd0);
`endif
        @(posedge clock_i); #1;
        reset_i = 1'b0;

        $display("[TB] frame 7: full frame after reset");
        for (int i = 0; i < 5; i++) stim[i] = 16'($urandom_range(0, 65535));
        base = issuedCnt;
        applyStimulus(5);
        waitDone(1'b0);
        checkOutput("issued_after_reset", 32'(issuedCnt - base), 32'd5);
        drainFrame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
